// File: rtl/pc_fetch_sequencer.sv
// PC/fetch control sequencer for the single-issue MIPS core.
// It steps through fetch, execute and PC update, and holds a sticky halt on timeout or a decoded halt.
module pc_fetch_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             Clk,
    input  logic             ReSetN,
    input  logic             IAck,
    input  logic             ExecDone,
    input  logic             IsBeq,
    input  logic             IsBne,
    input  logic             IsJ,
    input  logic             IsJr,
    input  logic             IsHalt,
    input  logic             Zero,
    input  logic             Stall,
    output logic             IReq,
    output logic             IrWrite,
    output logic             PcWrite,
    output logic [2:0]       Branch,
    output logic             PcSel,
    output logic             Halted,
    output logic [CNT_W-1:0] RetireCnt,
    output logic [CNT_W-1:0] RedirCnt
);

    localparam int unsigned TO_W = 8;

    localparam logic [2:0] BR_JR  = 3'b111;
    localparam logic [2:0] BR_J   = 3'b011;
    localparam logic [2:0] BR_BEQ = 3'b010;
    localparam logic [2:0] BR_BNE = 3'b001;
    localparam logic [2:0] BR_SEQ = 3'b000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        UPDATE = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              beq_q, bne_q, j_q, jr_q, zero_q;
    logic              beq_d, bne_d, j_d, jr_d, zero_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              ireq_d, pcwrite_d, pcsel_d, halted_d;
    logic [2:0]        branch_d;
    logic [CNT_W-1:0]  retire_d, redir_d;

    // State, latched decode and registered outputs
    always_ff @(posedge Clk or negedge ReSetN) begin
        if (!ReSetN) begin
            state_q   <= IDLE;
            beq_q     <= 1'b0;
            bne_q     <= 1'b0;
            j_q       <= 1'b0;
            jr_q      <= 1'b0;
            zero_q    <= 1'b0;
            tcnt_q    <= '0;
            IReq      <= 1'b0;
            PcWrite   <= 1'b0;
            Branch    <= BR_SEQ;
            PcSel     <= 1'b0;
            Halted    <= 1'b0;
            RetireCnt <= '0;
            RedirCnt  <= '0;
        end else begin
            state_q   <= state_d;
            beq_q     <= beq_d;
            bne_q     <= bne_d;
            j_q       <= j_d;
            jr_q      <= jr_d;
            zero_q    <= zero_d;
            tcnt_q    <= tcnt_d;
            IReq      <= ireq_d;
            PcWrite   <= pcwrite_d;
            Branch    <= branch_d;
            PcSel     <= pcsel_d;
            Halted    <= halted_d;
            RetireCnt <= retire_d;
            RedirCnt  <= redir_d;
        end
    end

    // Next state, plus output values for the cycle the next state occupies
    always_comb begin
        state_d  = state_q;
        beq_d    = beq_q;
        bne_d    = bne_q;
        j_d      = j_q;
        jr_d     = jr_q;
        zero_d   = zero_q;
        tcnt_d   = tcnt_q;
        retire_d = RetireCnt;
        redir_d  = RedirCnt;
        branch_d = BR_SEQ;
        pcsel_d  = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (IAck) begin
                    state_d = EXEC;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = TO_W'(tcnt_q + TO_W'(1));
                    if (tcnt_d == TO_W'(TIMEOUT)) state_d = HALT;
                end
            end
            EXEC: begin
                if (ExecDone) begin
                    beq_d   = IsBeq;
                    bne_d   = IsBne;
                    j_d     = IsJ;
                    jr_d    = IsJr;
                    zero_d  = Zero;
                    state_d = IsHalt ? HALT : UPDATE;
                end
            end
            UPDATE: begin
                // PcWrite was decided from Stall on the edge entering this cycle
                if (PcWrite) begin
                    state_d  = FETCH;
                    retire_d = CNT_W'(RetireCnt + CNT_W'(1));
                    if (Branch == BR_JR || Branch == BR_J || PcSel)
                        redir_d = CNT_W'(RedirCnt + CNT_W'(1));
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase

        ireq_d    = (state_d == FETCH);
        halted_d  = (state_d == HALT);
        pcwrite_d = (state_d == UPDATE) && !PcWrite && !Stall;

        if (state_d == UPDATE) begin
            if (jr_d) begin
                branch_d = BR_JR;
            end else if (j_d) begin
                branch_d = BR_J;
            end else if (beq_d) begin
                branch_d = BR_BEQ;
                pcsel_d  = zero_d;
            end else if (bne_d) begin
                branch_d = BR_BNE;
                pcsel_d  = !zero_d;
            end
        end
    end

    assign IrWrite = (state_q == FETCH) && IAck;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer; PC updates are scored against a queue of expected branch codes.
module tb_pc_fetch_sequencer;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TIMEOUT = 4;

    logic             Clk = 1'b0;
    logic             ReSetN = 1'b0;
    logic             IAck = 1'b0;
    logic             ExecDone = 1'b0;
    logic             IsBeq = 1'b0;
    logic             IsBne = 1'b0;
    logic             IsJ = 1'b0;
    logic             IsJr = 1'b0;
    logic             IsHalt = 1'b0;
    logic             Zero = 1'b0;
    logic             Stall = 1'b0;
    logic             IReq, IrWrite, PcWrite, PcSel, Halted;
    logic [2:0]       Branch;
    logic [CNT_W-1:0] RetireCnt, RedirCnt;

    int               n_assert = 0;
    int               n_fail = 0;
    int               exp_retire = 0;
    int               exp_redir = 0;
    logic [3:0]       exp_q[$];
    logic [3:0]       mon_e;

    pc_fetch_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .ReSetN(ReSetN), .IAck(IAck), .ExecDone(ExecDone),
        .IsBeq(IsBeq), .IsBne(IsBne), .IsJ(IsJ), .IsJr(IsJr), .IsHalt(IsHalt),
        .Zero(Zero), .Stall(Stall), .IReq(IReq), .IrWrite(IrWrite),
        .PcWrite(PcWrite), .Branch(Branch), .PcSel(PcSel), .Halted(Halted),
        .RetireCnt(RetireCnt), .RedirCnt(RedirCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] br, input logic ps);
        exp_q.push_back({br, ps});
        exp_retire++;
        if (br == 3'b111 || br == 3'b011 || ps) exp_redir++;
    endtask

    // Scoreboard: every PcWrite pulse consumes one expected {Branch, PcSel}
    always @(negedge Clk) begin
        if (ReSetN && PcWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("pcwrite_unexpected", 32'(PcWrite), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_branch", 32'(Branch), 32'(mon_e[3:1]));
                chk("sb_pcsel", 32'(PcSel), 32'(mon_e[0]));
                chk("sb_irwrite_excl", 32'(IrWrite), 32'd0);
            end
        end
    end

    // One instruction: fetch (after 'waits' unacked cycles), execute, then update (after 'stalls' held cycles)
    task automatic instr(input string tag, input logic beq, input logic bne, input logic j,
                         input logic jr, input logic hlt, input logic z, input int waits,
                         input int stalls, input logic [2:0] ebr, input logic eps);
        int guard;
        guard = 0;
        while (IReq !== 1'b1 && guard < 8) begin
            @(negedge Clk);
            guard++;
        end
        chk({tag, "_ireq"}, 32'(IReq), 32'd1);
        IAck = 1'b0;
        for (int w = 0; w < waits; w++) begin
            #1 chk({tag, "_wait_irwrite"}, 32'(IrWrite), 32'd0);
            @(negedge Clk);
            chk({tag, "_wait_ireq"}, 32'(IReq), 32'd1);
        end
        IsBeq = beq; IsBne = bne; IsJ = j; IsJr = jr; IsHalt = hlt; Zero = z;
        ExecDone = 1'b1;
        Stall = (stalls > 0);
        IAck = 1'b1;
        #1 chk({tag, "_irwrite"}, 32'(IrWrite), 32'd1);
        if (!hlt) push(ebr, eps);
        @(negedge Clk);
        IAck = 1'b0;
        chk({tag, "_exec_ireq"}, 32'(IReq), 32'd0);
        @(negedge Clk);
        ExecDone = 1'b0;
        IsBeq = 1'b0; IsBne = 1'b0; IsJ = 1'b0; IsJr = 1'b0; IsHalt = 1'b0; Zero = ~z;
        if (!hlt) begin
            for (int s = 0; s < stalls; s++) begin
                chk({tag, "_stall_pcwrite"}, 32'(PcWrite), 32'd0);
                chk({tag, "_stall_branch"}, 32'(Branch), 32'(ebr));
                if (s == stalls - 1) Stall = 1'b0;
                @(negedge Clk);
            end
            chk({tag, "_pcwrite"}, 32'(PcWrite), 32'd1);
        end
    endtask

    initial begin
        int last, npw, cyc, n;

        #7;
        chk("rst_ireq", 32'(IReq), 32'd0);
        chk("rst_irwrite", 32'(IrWrite), 32'd0);
        chk("rst_pcwrite", 32'(PcWrite), 32'd0);
        chk("rst_branch", 32'(Branch), 32'd0);
        chk("rst_pcsel", 32'(PcSel), 32'd0);
        chk("rst_halted", 32'(Halted), 32'd0);
        chk("rst_retire", RetireCnt, 32'd0);
        chk("rst_redir", RedirCnt, 32'd0);

        @(negedge Clk);
        ReSetN = 1'b1;
        @(negedge Clk);
        chk("first_ireq", 32'(IReq), 32'd1);

        // Zero-wait memory, immediate ExecDone: ten sequential instructions
        IAck = 1'b1;
        ExecDone = 1'b1;
        for (int i = 0; i < 10; i++) push(3'b000, 1'b0);
        last = 0; npw = 0; cyc = 0;
        while (npw < 10 && cyc < 60) begin
            if (PcWrite === 1'b1) begin
                if (npw > 0) chk("pcw_spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                npw++;
            end
            if (npw < 10) begin
                @(negedge Clk);
                cyc++;
            end
        end
        chk("steady_pcw_count", 32'(npw), 32'd10);
        IAck = 1'b0;
        ExecDone = 1'b0;
        @(negedge Clk);
        chk("steady_retire", RetireCnt, 32'(exp_retire));
        chk("steady_redir", RedirCnt, 32'(exp_redir));

        instr("beq_t",   1, 0, 0, 0, 0, 1, 0, 0, 3'b010, 1'b1);
        instr("beq_nt",  1, 0, 0, 0, 0, 0, 3, 0, 3'b010, 1'b0);
        instr("jr_j",    0, 0, 1, 1, 0, 0, 0, 0, 3'b111, 1'b0);
        instr("bne_t",   0, 1, 0, 0, 0, 0, 1, 0, 3'b001, 1'b1);
        instr("stall",   1, 0, 0, 0, 0, 1, 0, 4, 3'b010, 1'b1);
        instr("bne_nt",  0, 1, 0, 0, 0, 1, 0, 0, 3'b001, 1'b0);
        instr("j",       0, 0, 1, 0, 0, 0, 2, 1, 3'b011, 1'b0);
        instr("beq_bne", 1, 1, 0, 0, 0, 0, 0, 0, 3'b010, 1'b0);
        @(negedge Clk);
        chk("mix_retire", RetireCnt, 32'(exp_retire));
        chk("mix_redir", RedirCnt, 32'(exp_redir));
        chk("mix_fetch_ireq", 32'(IReq), 32'd1);

        // Reset asserted mid-fetch must drop IReq before the next clock edge
        #2 ReSetN = 1'b0;
        #1;
        chk("async_ireq", 32'(IReq), 32'd0);
        chk("async_retire", RetireCnt, 32'd0);
        chk("async_redir", RedirCnt, 32'd0);
        exp_retire = 0;
        exp_redir = 0;
        @(negedge Clk);
        ReSetN = 1'b1;

        instr("pre_halt", 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1'b0);
        instr("halt",     0, 0, 0, 0, 1, 0, 0, 0, 3'b000, 1'b0);
        chk("halt_halted", 32'(Halted), 32'd1);
        chk("halt_pcwrite", 32'(PcWrite), 32'd0);
        chk("halt_ireq", 32'(IReq), 32'd0);
        chk("halt_retire", RetireCnt, 32'(exp_retire));
        IAck = 1'b1;
        ExecDone = 1'b1;
        repeat (3) @(negedge Clk);
        chk("halt_sticky", 32'(Halted), 32'd1);
        chk("halt_sticky_ireq", 32'(IReq), 32'd0);
        chk("halt_sticky_irwrite", 32'(IrWrite), 32'd0);
        chk("halt_sticky_retire", RetireCnt, 32'(exp_retire));
        IAck = 1'b0;
        ExecDone = 1'b0;
        ReSetN = 1'b0;
        #1;
        chk("halt_rst_halted", 32'(Halted), 32'd0);
        chk("halt_rst_retire", RetireCnt, 32'd0);
        exp_retire = 0;
        exp_redir = 0;
        @(negedge Clk);
        ReSetN = 1'b1;

        // Fetch timeout: IAck never arrives
        @(negedge Clk);
        n = 0;
        while (IReq === 1'b1 && n < 10) begin
            n++;
            @(negedge Clk);
        end
        chk("to_ireq_cycles", 32'(n), 32'(TIMEOUT));
        chk("to_halted", 32'(Halted), 32'd1);
        chk("to_ireq_low", 32'(IReq), 32'd0);
        IAck = 1'b1;
        ExecDone = 1'b1;
        repeat (2) @(negedge Clk);
        IAck = 1'b0;
        ExecDone = 1'b0;
        chk("to_ignore_halted", 32'(Halted), 32'd1);
        chk("to_ignore_pcwrite", 32'(PcWrite), 32'd0);
        chk("to_ignore_ireq", 32'(IReq), 32'd0);
        chk("to_ignore_retire", RetireCnt, 32'd0);
        ReSetN = 1'b0;
        #1;
        chk("to_rst_halted", 32'(Halted), 32'd0);
        chk("to_rst_ireq", 32'(IReq), 32'd0);
        chk("to_rst_branch", 32'(Branch), 32'd0);
        chk("to_rst_pcsel", 32'(PcSel), 32'd0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Multi-cycle control FSM that sequences the program-counter register and the instruction fetch in the single-issue MIPS core.
- Issues fetch requests to instruction memory and waits for the memory acknowledge. Then waits for the execute stage to finish.
- Drives the PC register's update controls: write strobe, 3-bit Branch code and PcSel. It also supports a stall hold, a fetch timeout and a sticky halt.
- Sits between the PC register, the instruction memory port, the decoder and the ALU zero flag.

Parameters:
TIMEOUT, 16, max cycles IReq may stay high without IAck before the block halts; legal range 1..255
CNT_W, 32, width of the retire and redirect counters

Ports:
Clk  input  1  rising-edge clock
ReSetN  input  1  asynchronous active-low reset
IAck  input  1  instruction memory acknowledge; instruction valid this cycle
ExecDone  input  1  execute stage finished the current instruction
IsBeq  input  1  decoded beq, sampled on ExecDone
IsBne  input  1  decoded bne, sampled on ExecDone
IsJ  input  1  decoded j/jal, sampled on ExecDone
IsJr  input  1  decoded jr, sampled on ExecDone
IsHalt  input  1  decoded halt/illegal, sampled on ExecDone
Zero  input  1  ALU zero flag, sampled on ExecDone
Stall  input  1  hazard hold; blocks PC update
IReq  output  1  fetch request to instruction memory
IrWrite  output  1  load instruction register
PcWrite  output  1  PC register update strobe
Branch  output  3  PC update code: 111 jr, 011 j, 010 beq, 001 bne, 000 sequential
PcSel  output  1  take branch offset (conditional branch taken)
Halted  output  1  sticky halt indication
RetireCnt  output  CNT_W  instructions retired
RedirCnt  output  CNT_W  taken branches plus jumps

Behaviour:
- States: IDLE, FETCH, EXEC, UPDATE, HALT, encoded in 3 bits.
- Reset (ReSetN=0, asynchronous):
  - state=IDLE; latched decode flags, Zero and the timeout counter cleared.
  - All outputs 0: IReq, IrWrite, PcWrite, Branch=000, PcSel, Halted, RetireCnt, RedirCnt.
  - Asserting reset mid-fetch drops IReq immediately, without waiting for a clock edge.
- IDLE: unconditionally go to FETCH on the next edge.
- FETCH:
  - IReq=1.
  - IrWrite=IAck, combinational; this is the only input-to-output combinational path.
  - IAck=1 -> EXEC; the timeout counter clears.
  - Otherwise the timeout counter increments. It reaching TIMEOUT with no IAck -> HALT.
  - A fetch that gets IAck in the first FETCH cycle gives 1-cycle fetch latency.
- EXEC:
  - Hold until ExecDone=1.
  - On that edge, latch IsBeq, IsBne, IsJ, IsJr, IsHalt and Zero.
  - Latched IsHalt=1 -> HALT (no PC update, no counter change). Otherwise -> UPDATE.
- UPDATE: outputs are decoded from the latched flags only.
  - Branch priority Jr > J > Beq > Bne > sequential, so simultaneous decode flags resolve to the highest one.
  - PcSel = (Beq code && Zero) || (Bne code && !Zero). PcSel is 0 for the jr, j and sequential codes.
  - Stall=1: PcWrite=0, remain in UPDATE. Branch and PcSel stay driven and stable.
  - Stall=0: PcWrite=1 for exactly one cycle, then -> FETCH.
  - On the PcWrite cycle, RetireCnt += 1. RedirCnt += 1 if Branch is 111 or 011, or if PcSel=1.
  - Both counters wrap modulo 2^CNT_W.
- Branch and PcSel are 000/0 in every state except UPDATE. PcWrite and IrWrite never assert together.
- HALT:
  - Halted=1; all other control outputs 0; counters frozen.
  - Only reset exits HALT.
- Steady-state sequential instruction, zero-wait memory, ExecDone in the first EXEC cycle, no stall: 3 cycles per instruction (FETCH, EXEC, UPDATE).
- ExecDone or IAck arriving in any state other than its own is ignored.

Test Plan:
- Release reset, tie IAck=1 and ExecDone=1, all decode flags 0 -> IReq in cycle 1 after IDLE; after 10 instructions, 10 PcWrite pulses 3 cycles apart, Branch=000, RetireCnt=10, RedirCnt=0.
- beq with Zero=1, then beq with Zero=0 -> first UPDATE: Branch=010, PcSel=1; second UPDATE: Branch=010, PcSel=0; RedirCnt=1.
- IsJr=1 and IsJ=1 together, then bne with Zero=0 -> Branch=111, PcSel=0 for the first; then Branch=001, PcSel=1; RedirCnt=2.
- Hold Stall=1 for 4 cycles in UPDATE -> PcWrite stays 0 for 4 cycles with Branch stable, then exactly one PcWrite pulse; RetireCnt increments once.
- With TIMEOUT=4, hold IAck=0 -> IReq high 4 cycles, then Halted=1 and IReq=0; later IAck or ExecDone pulses cause no change; ReSetN low restores all outputs to 0.
- Pulse ReSetN low mid-FETCH with IReq=1 -> IReq falls asynchronously before the next Clk edge; counters read 0 after release.
- IsHalt=1 on ExecDone -> no PcWrite, Halted=1 on the next cycle, RetireCnt unchanged.
